// File: rtl/iphu_pkg.sv
// iphu_pkg: shared types and constants for the multi-lane inport protocol
// handler (iphu_mlane / iphu_lane).
package iphu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALF = 2'd1,
    PEND = 2'd2,
    ERR  = 2'd3
  } lane_state_e;

  // Idle levels of the two-phase pair: p rests high, n rests low.
  localparam logic P_REF_RST = 1'b1;
  localparam logic N_REF_RST = 1'b0;

  localparam int LANES_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SKEW_CYCLES_DEF = 3;
  localparam int CNT_W_DEF       = 16;

  // Width of the skew counter: it only has to hold 0 .. SKEW_CYCLES-1.
  function automatic int skew_cnt_w(input int skew_cycles);
    return (skew_cycles > 2) ? $clog2(skew_cycles) : 1;
  endfunction

endpackage

// File: rtl/iphu_lane.sv
// iphu_lane: one two-phase differential lane. Synchronises p/n, tolerates
// bounded skew between them, filters single-wire glitches, presents a
// pipe_en/pipe_ready handshake and returns a two-phase ack toggle.
// Optional per-lane event/error counters when IPHU_EVENT_CNT_EN is defined.
//
// state | meaning
// IDLE  | both wires match their references, waiting for a transition
// HALF  | exactly one wire has toggled, counting skew cycles
// PEND  | both wires toggled, event offered downstream (pipe_en=1)
// ERR   | skew limit exceeded, sticky error until clear_err
module iphu_lane
  import iphu_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int SKEW_CYCLES = SKEW_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p,
  input  logic             n,
  input  logic             pipe_ready,
  input  logic             clear_err,
  output logic             pipe_en,
  output logic             ack_toggle,
  output logic             error
`ifdef IPHU_EVENT_CNT_EN
  ,
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] error_count
`endif
);

  localparam int SKW_W = skew_cnt_w(SKEW_CYCLES);
  localparam logic [SKW_W-1:0] SKEW_LAST = SKW_W'(SKEW_CYCLES - 1);

  logic [SYNC_STAGES-1:0] p_sync;
  logic [SYNC_STAGES-1:0] n_sync;
  logic                   p_s;
  logic                   n_s;
  logic                   p_ref;
  logic                   n_ref;
  logic                   dp;
  logic                   dn;
  logic [SKW_W-1:0]       skew_cnt;
  lane_state_e            state;
  logic                   hs_done;
  logic                   err_enter;

  // Synchronisers; reset values match the idle wire levels so release is quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_sync <= {SYNC_STAGES{P_REF_RST}};
      n_sync <= {SYNC_STAGES{N_REF_RST}};
    end else begin
      p_sync <= {p_sync[SYNC_STAGES-2:0], p};
      n_sync <= {n_sync[SYNC_STAGES-2:0], n};
    end
  end

  assign p_s = p_sync[SYNC_STAGES-1];
  assign n_s = n_sync[SYNC_STAGES-1];
  assign dp  = p_s ^ p_ref;
  assign dn  = n_s ^ n_ref;

  // In HALF exactly one of dp/dn is set whenever the state is neither resolved
  // nor abandoned, so the counter limit alone decides the error.
  assign hs_done   = (state == PEND) && pipe_ready;
  assign err_enter = (state == HALF) && (dp ^ dn) && (skew_cnt == SKEW_LAST);

  // Lane FSM with registered pipe_en / ack_toggle / error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      p_ref      <= P_REF_RST;
      n_ref      <= N_REF_RST;
      skew_cnt   <= '0;
      pipe_en    <= 1'b0;
      ack_toggle <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dp && dn) begin
            state   <= PEND;
            pipe_en <= 1'b1;
          end else if (dp ^ dn) begin
            state    <= HALF;
            skew_cnt <= '0;
          end
        end
        HALF: begin
          if (dp && dn) begin
            state   <= PEND;
            pipe_en <= 1'b1;
          end else if (!dp && !dn) begin
            state <= IDLE;
          end else if (err_enter) begin
            state <= ERR;
            error <= 1'b1;
          end else begin
            skew_cnt <= skew_cnt + 1'b1;
          end
        end
        PEND: begin
          // Wires are not examined here; a change during PEND is seen
          // against the inverted references once back in IDLE.
          if (hs_done) begin
            state      <= IDLE;
            pipe_en    <= 1'b0;
            p_ref      <= ~p_ref;
            n_ref      <= ~n_ref;
            ack_toggle <= ~ack_toggle;
          end
        end
        ERR: begin
          if (clear_err) begin
            p_ref <= p_s;
            n_ref <= n_s;
            // Equal wires cannot be a valid idle pair, so stay errored.
            if (p_s != n_s) begin
              state <= IDLE;
              error <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          pipe_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef IPHU_EVENT_CNT_EN
  // Saturating handshake and error-entry counters; clear_err leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_count <= '0;
      error_count <= '0;
    end else begin
      if (hs_done && (event_count != {CNT_W{1'b1}}))
        event_count <= event_count + 1'b1;
      if (err_enter && (error_count != {CNT_W{1'b1}}))
        error_count <= error_count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/iphu_mlane.sv
// iphu_mlane: multi-lane inport protocol handler. LANES independent
// two-phase differential lanes, each an iphu_lane instance.
// Define IPHU_EVENT_CNT_EN to add the event_count / error_count outputs.
module iphu_mlane
  import iphu_pkg::*;
#(
  parameter int LANES       = LANES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int SKEW_CYCLES = SKEW_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       diff_pair_p,
  input  logic [LANES-1:0]       diff_pair_n,
  input  logic [LANES-1:0]       pipe_ready,
  input  logic [LANES-1:0]       clear_err,
  output logic [LANES-1:0]       pipe_en,
  output logic [LANES-1:0]       ack_toggle,
  output logic [LANES-1:0]       error
`ifdef IPHU_EVENT_CNT_EN
  ,
  output logic [LANES*CNT_W-1:0] event_count,
  output logic [LANES*CNT_W-1:0] error_count
`endif
);

  // One independent lane per differential pair.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    iphu_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .SKEW_CYCLES (SKEW_CYCLES),
      .CNT_W       (CNT_W)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .p           (diff_pair_p[g]),
      .n           (diff_pair_n[g]),
      .pipe_ready  (pipe_ready[g]),
      .clear_err   (clear_err[g]),
      .pipe_en     (pipe_en[g]),
      .ack_toggle  (ack_toggle[g]),
      .error       (error[g])
`ifdef IPHU_EVENT_CNT_EN
      ,
      .event_count (event_count[g*CNT_W +: CNT_W]),
      .error_count (error_count[g*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_iphu_mlane.sv
// tb_iphu_mlane: scoreboard bench for iphu_mlane (LANES=4, SYNC_STAGES=2,
// SKEW_CYCLES=3). Inputs change 1 ns after a falling edge; the main thread
// samples on falling edges, the handshake monitor 2 ns after them.
module tb_iphu_mlane;

  localparam int LANES = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [LANES-1:0] diff_pair_p;
  logic [LANES-1:0] diff_pair_n;
  logic [LANES-1:0] pipe_ready;
  logic [LANES-1:0] clear_err;
  logic [LANES-1:0] pipe_en;
  logic [LANES-1:0] ack_toggle;
  logic [LANES-1:0] error;
`ifdef IPHU_EVENT_CNT_EN
  logic [LANES*CNT_W-1:0] event_count;
  logic [LANES*CNT_W-1:0] error_count;
`endif

  iphu_mlane #(
    .LANES       (LANES),
    .SYNC_STAGES (2),
    .SKEW_CYCLES (3),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .diff_pair_p (diff_pair_p),
    .diff_pair_n (diff_pair_n),
    .pipe_ready  (pipe_ready),
    .clear_err   (clear_err),
    .pipe_en     (pipe_en),
    .ack_toggle  (ack_toggle),
    .error       (error)
`ifdef IPHU_EVENT_CNT_EN
    ,
    .event_count (event_count),
    .error_count (error_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per lane: the ack_toggle value expected just before each handshake.
  logic q_ack [LANES][$];
  logic [LANES-1:0] exp_ack;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one full event (both wires toggle) on each lane in mask.
  task automatic event_on(input logic [LANES-1:0] mask);
    for (int l = 0; l < LANES; l++) begin
      if (mask[l]) begin
        q_ack[l].push_back(exp_ack[l]);
        exp_ack[l] = ~exp_ack[l];
      end
    end
    diff_pair_p = diff_pair_p ^ mask;
    diff_pair_n = diff_pair_n ^ mask;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: a handshake completes on the next rising edge wherever
  // pipe_en and pipe_ready are both high now.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        for (int l = 0; l < LANES; l++) begin
          if (pipe_en[l] && pipe_ready[l]) begin
            if (q_ack[l].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_handshake lane %0d: pipe_en=1, expected 0", l);
            end else begin
              check($sformatf("ack_before_handshake_lane%0d", l), 64'(ack_toggle[l]),
                    64'(q_ack[l].pop_front()));
              check($sformatf("error_at_handshake_lane%0d", l), 64'(error[l]), 64'd0);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    diff_pair_p = 4'hF;
    diff_pair_n = 4'h0;
    pipe_ready  = 4'h0;
    clear_err   = 4'h0;
    exp_ack     = 4'h0;

    wait_neg(3);
    check("reset_pipe_en", 64'(pipe_en), 64'h0);
    check("reset_ack", 64'(ack_toggle), 64'h0);
    check("reset_error", 64'(error), 64'h0);
    #1 reset = 1'b0;
    wait_neg(4);
    check("post_release_quiet", 64'({pipe_en, ack_toggle, error}), 64'h0);

    // Lane 0: aligned event, ready held high -> one-cycle pipe_en at +3.
    #1 pipe_ready[0] = 1'b1;
    event_on(4'b0001);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("lane0_pipe_en_cycle%0d", i), 64'(pipe_en), (i == 3) ? 64'h1 : 64'h0);
    end
    check("lane0_ack", 64'(ack_toggle), 64'h1);

    // Lane 1: held pending for 10 cycles, then released.
    #1 event_on(4'b0010);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check($sformatf("lane1_hold_cycle%0d", i), 64'(pipe_en[1]), (i >= 3) ? 64'h1 : 64'h0);
    end
    #1 pipe_ready[1] = 1'b1;
    @(negedge clk);
    check("lane1_drop_after_ready", 64'(pipe_en[1]), 64'h0);
    check("lane1_ack", 64'(ack_toggle), 64'h3);

    // Lane 1: one extra event during PEND is preserved.
    #1 pipe_ready[1] = 1'b0;
    event_on(4'b0010);
    wait_neg(4);
    #1 event_on(4'b0010);
    wait_neg(4);
    check("lane1_pend_with_extra", 64'(pipe_en[1]), 64'h1);
    #1 pipe_ready[1] = 1'b1;
    wait_neg(8);
    check("lane1_two_events_ack", 64'(ack_toggle[1]), 64'(exp_ack[1]));
    check("lane1_idle_after_two", 64'(pipe_en[1]), 64'h0);

    // Lane 2: 2-cycle skew is tolerated.
    #1 pipe_ready[2] = 1'b1;
    q_ack[2].push_back(exp_ack[2]);
    exp_ack[2] = ~exp_ack[2];
    diff_pair_p[2] = ~diff_pair_p[2];
    wait_neg(2);
    #1 diff_pair_n[2] = ~diff_pair_n[2];
    wait_neg(8);
    check("lane2_skew2_error", 64'(error[2]), 64'h0);
    check("lane2_skew2_ack", 64'(ack_toggle[2]), 64'(exp_ack[2]));

    // Lane 2: 5-cycle skew -> error, no event.
    #1 diff_pair_p[2] = ~diff_pair_p[2];
    wait_neg(5);
    #1 diff_pair_n[2] = ~diff_pair_n[2];
    wait_neg(6);
    check("lane2_skew5_error", 64'(error[2]), 64'h1);
    check("lane2_skew5_no_pipe_en", 64'(pipe_en[2]), 64'h0);
    check("lane2_skew5_ack", 64'(ack_toggle[2]), 64'(exp_ack[2]));

    // Lane 2 recovery: wires p=0 n=1, pulse clear_err.
    #1 diff_pair_p[2] = 1'b0;
    diff_pair_n[2] = 1'b1;
    wait_neg(4);
    check("lane2_err_sticky", 64'(error[2]), 64'h1);
    #1 clear_err[2] = 1'b1;
    @(negedge clk);
    check("lane2_cleared", 64'(error[2]), 64'h0);
    #1 clear_err[2] = 1'b0;
    event_on(4'b0100);
    wait_neg(6);
    check("lane2_recovered_ack", 64'(ack_toggle[2]), 64'(exp_ack[2]));
    check("lane2_recovered_error", 64'(error[2]), 64'h0);

    // Lane 3: clear_err outside ERR is ignored, then a one-cycle glitch.
    #1 clear_err[3] = 1'b1;
    pipe_ready[3] = 1'b1;
    @(negedge clk);
    #1 clear_err[3] = 1'b0;
    diff_pair_p[3] = ~diff_pair_p[3];
    @(negedge clk);
    #1 diff_pair_p[3] = ~diff_pair_p[3];
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("lane3_glitch_cycle%0d", i), 64'(pipe_en[3]), 64'h0);
    end
    check("lane3_glitch_error", 64'(error[3]), 64'h0);
    check("lane3_glitch_ack", 64'(ack_toggle[3]), 64'h0);

    // All lanes at once.
    #1 pipe_ready = 4'hF;
    event_on(4'hF);
    wait_neg(3);
    check("all_lanes_pipe_en", 64'(pipe_en), 64'hF);
    wait_neg(3);
    check("all_lanes_ack", 64'(ack_toggle), 64'(exp_ack));
    check("all_lanes_error", 64'(error), 64'h0);

`ifdef IPHU_EVENT_CNT_EN
    check("event_count", 64'(event_count), {16'd1, 16'd3, 16'd4, 16'd2});
    check("error_count", 64'(error_count), {16'd0, 16'd0, 16'd1, 16'd0} << 0 == 64'h0
          ? 64'h0 : {16'd0, 16'd1, 16'd0, 16'd0});
`endif

    // Reset while lane 0 is pending.
    #1 pipe_ready[0] = 1'b0;
    event_on(4'b0001);
    wait_neg(4);
    check("lane0_pend_before_reset", 64'(pipe_en[0]), 64'h1);
    #1 reset = 1'b1;
    q_ack[0].delete();
    exp_ack = 4'h0;
    diff_pair_p = 4'hF;
    diff_pair_n = 4'h0;
    #1;
    check("reset_mid_pipe_en", 64'(pipe_en), 64'h0);
    check("reset_mid_ack", 64'(ack_toggle), 64'h0);
    check("reset_mid_error", 64'(error), 64'h0);
`ifdef IPHU_EVENT_CNT_EN
    check("reset_mid_event_count", 64'(event_count), 64'h0);
`endif
    wait_neg(2);
    #1 reset = 1'b0;
    wait_neg(6);
    check("after_reset_quiet", 64'({pipe_en, ack_toggle, error}), 64'h0);

    for (int l = 0; l < LANES; l++)
      check($sformatf("scoreboard_empty_lane%0d", l), 64'(q_ack[l].size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iphu_mlane.md
Name: iphu_mlane

Overview:
- Multi-lane successor of the inport protocol handler.
- Each lane receives a two-phase (transition-signalled) differential pair. An event is one toggle of both wires.
- Each lane synchronises its pair, tolerates bounded p/n skew, filters single-wire glitches, and flags protocol errors.
- Each lane presents a pipe_en/pipe_ready handshake to the downstream pipeline and returns a two-phase ack toggle upstream.
- Sits at every router input port, ahead of the input buffer.

Parameters:
- LANES, 4: number of independent differential-pair lanes.
- SYNC_STAGES, 2: synchroniser flops per wire, minimum 2.
- SKEW_CYCLES, 3: maximum cycles one wire may lead the other before error.
- CNT_W, 16: width of the optional event counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- diff_pair_p  in  LANES  positive wire per lane, asynchronous.
- diff_pair_n  in  LANES  negative wire per lane, asynchronous.
- pipe_ready  in  LANES  downstream accepts the lane's pending event.
- clear_err  in  LANES  single-cycle pulse; resynchronises an errored lane.
- pipe_en  out  LANES  lane holds a pending event.
- ack_toggle  out  LANES  two-phase acknowledge to upstream.
- error  out  LANES  sticky protocol error per lane.

Behaviour:
- Reset (asynchronous, active-high):
  - p synchroniser flops reset to 1; n synchroniser flops reset to 0.
  - Per lane: p_ref=1, n_ref=0, state=IDLE, skew counter=0.
  - Outputs: pipe_en=0, ack_toggle=0, error=0.
  - Reset mid-operation drops any pending event; no output glitches after release.
- Each wire passes through SYNC_STAGES flops, giving p_s and n_s. dp = p_s!=p_ref, dn = n_s!=n_ref.
- Per-lane FSM, registered:
  - IDLE:
    - dp&dn -> PEND.
    - dp^dn -> HALF, counter cleared to 0.
    - Otherwise stay.
  - HALF:
    - dp&dn -> PEND.
    - !dp&!dn (glitch returned) -> IDLE, no event.
    - Otherwise the counter increments; when it reaches SKEW_CYCLES-1 with the other wire still unchanged -> ERR.
  - PEND:
    - pipe_en=1 while in this state.
    - When pipe_ready=1: handshake completes that cycle; p_ref and n_ref invert; ack_toggle inverts; next state IDLE.
  - ERR:
    - error=1, pipe_en=0.
    - clear_err=1: load p_ref<=p_s, n_ref<=n_s. Go to IDLE if p_s!=n_s; stay in ERR if p_s==n_s.
- Latency: input change to pipe_en high is SYNC_STAGES+1 cycles. pipe_en is a registered-state decode.
- Wire changes during PEND are not sampled until the handshake completes, then compared against the inverted refs.
  - One further event during PEND is preserved.
  - Two further events during PEND cancel out. This is upstream protocol violation; upstream must wait for ack.
- clear_err outside ERR is ignored.
- pipe_ready outside PEND is ignored.
- Lanes are fully independent; simultaneous events on all lanes are handled in parallel.

Optional Feature:
- Macro: IPHU_EVENT_CNT_EN.
- Defined:
  - Adds output event_count (LANES*CNT_W): per-lane count of completed handshakes.
  - Adds output error_count (LANES*CNT_W): per-lane count of ERR entries.
  - Both counters saturate at all-ones, reset to 0, and are not cleared by clear_err.
- Undefined: neither port nor any counter logic exists. All other behaviour is identical.

Decomposition:
- Package iphu_pkg:
  - lane state enum: IDLE, HALF, PEND, ERR.
  - P_REF_RST=1'b1, N_REF_RST=1'b0.
  - default parameter constants.
- Sub-module iphu_lane: synchroniser, FSM, skew counter, ack and optional counters for one lane.
- The top level instantiates iphu_lane LANES times in a generate loop.

Test Plan (LANES=4, SYNC_STAGES=2, SKEW_CYCLES=3):
- Lane 0: p 1->0 and n 0->1 together, pipe_ready=1 -> pipe_en[0] high for exactly 1 cycle, 3 cycles after the change; ack_toggle[0] goes 0->1; other lanes stay 0.
- Lane 1: pipe_ready[1]=0 with one event -> pipe_en[1] held high for 10 cycles. Then raise pipe_ready -> pipe_en drops next cycle; ack toggles once.
- Lane 2 skew: n toggles 2 cycles after p -> one pipe_en, error=0. Repeat with a 5-cycle gap -> error[2]=1; no pipe_en.
- Lane 3 glitch: p toggles and returns after 1 cycle -> no pipe_en, no error, ack unchanged.
- Lane 2 recovery: in ERR with p=0, n=1, pulse clear_err[2] -> error[2]=0 next cycle. Next full toggle to p=1, n=0 -> pipe_en[2].
- Reset asserted while lane 0 is in PEND -> pipe_en, ack_toggle and error all 0 immediately. With IPHU_EVENT_CNT_EN defined, event_count=0.
